// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder slice.
// Provides the FSM state type, counter width, word geometry and an
// alignment helper used by the responder top level.
package dmem_pkg;

  localparam int CNT_W      = 4;
  localparam int WORD_BYTES = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // A byte address is word-aligned when its low two bits are clear.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array for the data-memory responder.
// Ports:
//   clk   - clock
//   we    - write enable (qualified by en)
//   en    - access enable; a read updates rdata only when en & !we
//   idx   - word index
//   wdata - write data
//   rdata - registered read data, holds until the next read access
// Contents are not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_wait_responder.sv
// Memory-stage data-memory responder with configurable wait states.
// Accepts a load/store from the EX/MEM register, stalls the pipeline for
// WAIT_CYCLES+1 cycles, then pulses RespValidM for one cycle while load
// data is presented on ReadDataM.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   MemReadM    - load request
//   MemWriteM   - store request (wins when both are set)
//   ALUResultM  - byte address; upper bits above the array alias
//   WriteDataM  - store data
//   ReadDataM   - load data, held until the next completed load
//   StallM      - freeze F/D/E/M while high
//   RespValidM  - access completes this cycle
//   MisalignM   - request address not word-aligned (IDLE only)
module dmem_wait_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        RespValidM,
  output logic        MisalignM
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  logic              rd_seen;

  logic              req;
  logic              aligned;
  logic              start;
  logic              access;
  logic              acc_write;
  logic [IDX_W-1:0]  acc_idx;
  logic [31:0]       acc_wdata;
  logic [31:0]       arr_rdata;

  // Address bits above the array index alias and do not take part.
  logic unused_addr;
  assign unused_addr = ^ALUResultM[31:IDX_W+2];

  assign req     = MemReadM | MemWriteM;
  assign aligned = is_aligned(ALUResultM[1:0]);
  assign start   = (state == IDLE) && req && aligned;

  // With zero wait states the access happens on the accepting edge, so the
  // array is fed straight from the inputs; otherwise from the latch.
  assign access = !reset &&
                  ((start && (WAIT_CYCLES == 0)) ||
                   ((state == WAIT) && (cnt == CNT_ONE)));

  assign acc_write = (state == IDLE) ? MemWriteM : write_q;
  assign acc_idx   = (state == IDLE) ? ALUResultM[IDX_W+1:2] : idx_q;
  assign acc_wdata = (state == IDLE) ? WriteDataM : wdata_q;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (access & acc_write),
    .en    (access),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LD;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (access && !acc_write) begin
        rd_seen <= 1'b1;
      end
    end
  end

  // Request latch: data path only, not reset.
  always_ff @(posedge clk) begin
    if (start) begin
      idx_q   <= ALUResultM[IDX_W+1:2];
      wdata_q <= WriteDataM;
      write_q <= MemWriteM;
    end
  end

  // The array read register is not reset, so ReadDataM shows zero until
  // the first load since reset has completed.
  assign ReadDataM  = rd_seen ? arr_rdata : 32'h0;

  assign StallM     = !reset && ((state == WAIT) || start);
  assign RespValidM = !reset && (state == DONE);
  assign MisalignM  = !reset && (state == IDLE) && req && !aligned;

endmodule

// File: tb/tb_dmem_wait_responder.sv
module tb_dmem_wait_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mr   [2];
  logic        mw   [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic [31:0] rdo  [2];
  logic        stall[2];
  logic        rv   [2];
  logic        mis  [2];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: word memory per instance plus the expected ReadDataM.
  logic [31:0] mem_m [2][256];
  bit          known [2][256];
  logic [31:0] rd_m  [2];

  always #5 clk = ~clk;

  dmem_wait_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .MemReadM(mr[0]), .MemWriteM(mw[0]),
    .ALUResultM(addr[0]), .WriteDataM(wd[0]), .ReadDataM(rdo[0]),
    .StallM(stall[0]), .RespValidM(rv[0]), .MisalignM(mis[0]));

  dmem_wait_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .MemReadM(mr[1]), .MemWriteM(mw[1]),
    .ALUResultM(addr[1]), .WriteDataM(wd[1]), .ReadDataM(rdo[1]),
    .StallM(stall[1]), .RespValidM(rv[1]), .MisalignM(mis[1]));

  // One memory instruction in M on instance s, checked cycle by cycle.
  task automatic access(input int s, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d,
                        input bit corrupt, input string nm);
    int wc;
    int idx;
    bit req;
    bit al;
    wc  = (s == 0) ? 2 : 0;
    idx = int'(a[9:2]);
    req = r | w;
    al  = (a[1:0] == 2'b00);
    @(negedge clk);
    mr[s] = r; mw[s] = w; addr[s] = a; wd[s] = d;
    #1;
    if (req && !al) begin
      n_chk++;
      if (mis[s] !== 1'b1 || stall[s] !== 1'b0 || rv[s] !== 1'b0)
        $display("FAIL %s misalign: mis=%b stall=%b rv=%b, want 1 0 0", nm, mis[s], stall[s], rv[s]);
      else n_pass++;
    end else if (req) begin
      if (w) begin
        mem_m[s][idx] = d;
        known[s][idx] = 1'b1;
      end else begin
        rd_m[s] = mem_m[s][idx];
      end
      for (int c = 0; c <= wc + 1; c++) begin
        n_chk++;
        if (stall[s] !== (c <= wc) || rv[s] !== (c == wc + 1) || mis[s] !== 1'b0)
          $display("FAIL %s cycle %0d: stall=%b rv=%b mis=%b, want %b %b 0",
                   nm, c, stall[s], rv[s], mis[s], (c <= wc), (c == wc + 1));
        else n_pass++;
        if (c == wc + 1 && r && !w) begin
          n_chk++;
          if (rdo[s] !== rd_m[s])
            $display("FAIL %s load data: got %h, want %h", nm, rdo[s], rd_m[s]);
          else n_pass++;
        end
        if (c < wc + 1) begin
          @(negedge clk);
          if (corrupt && c == 0) begin
            addr[s] = 32'h20;
            wd[s]   = 32'h0;
          end
          #1;
        end
      end
    end
    @(negedge clk);
    mr[s] = 1'b0; mw[s] = 1'b0; addr[s] = $urandom; wd[s] = $urandom;
    #1;
    n_chk++;
    if (stall[s] !== 1'b0 || rv[s] !== 1'b0 || mis[s] !== 1'b0 || rdo[s] !== rd_m[s])
      $display("FAIL %s idle after: stall=%b rv=%b mis=%b rd=%h, want 0 0 0 %h",
               nm, stall[s], rv[s], mis[s], rdo[s], rd_m[s]);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mr[0] = 1'b1; mw[0] = 1'b0; addr[0] = 32'h10; wd[0] = 32'h0;
    mr[1] = 1'b1; mw[1] = 1'b0; addr[1] = 32'h13; wd[1] = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_chk++;
      if (stall[s] !== 1'b0 || mis[s] !== 1'b0 || rv[s] !== 1'b0 || rdo[s] !== 32'h0)
        $display("FAIL reset[%0d]: stall=%b mis=%b rv=%b rd=%h, want 0 0 0 0",
                 s, stall[s], mis[s], rv[s], rdo[s]);
      else n_pass++;
      mr[s] = 1'b0; mw[s] = 1'b0;
      rd_m[s] = 32'h0;
    end
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, "store_0x10");
    access(0, 1, 0, 32'h10, 32'h0, 0, "load_0x10");
  endtask

  task automatic test_zero_wait();
    access(1, 0, 1, 32'h0, 32'h12345678, 0, "zw_store_0x0");
    access(1, 1, 0, 32'h0, 32'h0, 0, "zw_load_0x0");
  endtask

  task automatic test_misalign();
    access(0, 0, 1, 32'h13, 32'h99999999, 0, "misalign_store_0x13");
    access(0, 1, 0, 32'h10, 32'h0, 0, "load_after_misalign");
    access(1, 1, 0, 32'h2, 32'h0, 0, "zw_misalign_load");
  endtask

  task automatic test_alias();
    access(0, 0, 1, 32'h400, 32'hA5A5A5A5, 0, "alias_store_0x400");
    access(0, 1, 0, 32'h000, 32'h0, 0, "alias_load_0x000");
  endtask

  task automatic test_corrupt();
    access(0, 0, 1, 32'h20, 32'h77777777, 0, "pre_store_0x20");
    access(0, 0, 1, 32'h10, 32'h11111111, 1, "corrupt_store_0x10");
    access(0, 1, 0, 32'h10, 32'h0, 0, "corrupt_load_0x10");
    access(0, 1, 0, 32'h20, 32'h0, 0, "corrupt_load_0x20");
  endtask

  task automatic test_reset_mid_store();
    access(0, 0, 1, 32'h8, 32'h55555555, 0, "pre_store_0x8");
    @(negedge clk);
    mr[0] = 1'b0; mw[0] = 1'b1; addr[0] = 32'h8; wd[0] = 32'hCAFEF00D;
    #1;
    n_chk++;
    if (stall[0] !== 1'b1)
      $display("FAIL rst_mid start stall: got %b, want 1", stall[0]);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mr[0] = 1'b0; mw[0] = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      rd_m[s] = 32'h0;
      n_chk++;
      if (stall[s] !== 1'b0 || rv[s] !== 1'b0 || rdo[s] !== 32'h0)
        $display("FAIL rst_mid[%0d]: stall=%b rv=%b rd=%h, want 0 0 0",
                 s, stall[s], rv[s], rdo[s]);
      else n_pass++;
    end
    access(0, 1, 0, 32'h8, 32'h0, 0, "load_0x8_after_reset");
  endtask

  task automatic test_random();
    int base [8];
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 8; k++) begin
        base[k] = int'($urandom_range(0, 255));
        access(s, 0, 1, {$urandom_range(0, 4095), 8'(base[k]), 2'b00}
                        & 32'h003F_FFFF, $urandom, 0, "rnd_prestore");
      end
      for (int n = 0; n < 40; n++) begin
        int k;
        int op;
        logic [31:0] a;
        k  = int'($urandom_range(0, 7));
        op = int'($urandom_range(0, 3));
        a  = {$urandom_range(0, 4095), 8'(base[k]), 2'b00} & 32'h003F_FFFF;
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        case (op)
          0, 1: access(s, 1, 0, a, $urandom, 0, "rnd_load");
          2:    access(s, 0, 1, a, $urandom, 0, "rnd_store");
          default: access(s, 1, 1, a, $urandom, 0, "rnd_both");
        endcase
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_zero_wait();
    test_misalign();
    test_alias();
    test_corrupt();
    test_reset_mid_store();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
